// File: rtl/rv32_trace_buf_if.sv
// rtl/rv32_trace_buf_if.sv - Interface bundle for the retirement-trace capture block
//
// Purpose:
//   Groups the WB retirement stream, trigger controls and debug readout of
//   rv32_trace_buf into a single interface.
//   slave  : used by rv32_trace_buf (consumes the retire/control inputs, drives readout).
//   master : used by the CPU/debug side (drives the retire/control inputs, observes readout).
//
// Signal summary:
//   wb_valid, wb_pc, wb_ir, wb_wdata   retirement record from WB
//   data_hazard, control_hazard        pipeline stall flags (gap metadata)
//   arm, trig_en, trig_pc              capture control and PC trigger
//   rd_idx, rd_field                   readout select (0 = oldest record)
//   rd_data, state, count, done        registered readout and capture status

interface rv32_trace_buf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic [31:0]     wb_ir;
  logic [XLEN-1:0] wb_wdata;
  logic            data_hazard;
  logic            control_hazard;
  logic            arm;
  logic            trig_en;
  logic [XLEN-1:0] trig_pc;
  logic [AW-1:0]   rd_idx;
  logic [1:0]      rd_field;
  logic [XLEN-1:0] rd_data;
  logic [1:0]      state;
  logic [AW:0]     count;
  logic            done;

  modport master (
    output wb_valid, wb_pc, wb_ir, wb_wdata, data_hazard, control_hazard,
    output arm, trig_en, trig_pc, rd_idx, rd_field,
    input  rd_data, state, count, done
  );

  modport slave (
    input  wb_valid, wb_pc, wb_ir, wb_wdata, data_hazard, control_hazard,
    input  arm, trig_en, trig_pc, rd_idx, rd_field,
    output rd_data, state, count, done
  );
endinterface

// File: rtl/rv32_trace_buf.sv
// rtl/rv32_trace_buf.sv - Retirement-trace circular buffer with PC trigger and post-trigger freeze
//
// Purpose:
//   Records every instruction retired in WB (PC, IR, write-back data and
//   optional gap/hazard metadata) into a DEPTH-entry circular buffer. A PC
//   trigger followed by POST_CNT further records freezes the buffer so the
//   window around the event can be read out on the debug path.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   dbg    slave modport of rv32_trace_buf_if (retire stream, trigger
//          controls, registered readout, state/count/done status)
//
// Optional feature:
//   TRACE_GAP_EN - when defined, each record carries meta =
//   {control_hazard_seen[17], data_hazard_seen[16], gap[15:0]} describing the
//   idle cycles preceding it. When undefined no meta storage is built and
//   rd_field = 3 reads 0.

module rv32_trace_buf #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int POST_CNT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rv32_trace_buf_if.slave dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_CNT);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] post_q, post_d;
  logic          wr_en;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     ir_mem [DEPTH];
  logic [XLEN-1:0] wd_mem [DEPTH];

  logic [AW-1:0]   rd_slot;
  logic [XLEN-1:0] ir_ext;
  logic [XLEN-1:0] meta_ext;
  logic [XLEN-1:0] rd_data_q;
  logic            trig_hit;

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  assign trig_hit = dbg.trig_en && (dbg.wb_pc == dbg.trig_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    wr_en    = 1'b0;

    if (dbg.arm) begin
      // arm wins over everything, including a record retiring this cycle
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (dbg.wb_valid) begin
            wr_en = 1'b1;
            if (trig_hit) begin
              post_d  = '0;
              state_d = (POST_CNT == 0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          // trigger matches are deliberately ignored here
          if (dbg.wb_valid) begin
            wr_en  = 1'b1;
            post_d = post_q + 1'b1;
            if (post_q + 1'b1 == POST_LAST) begin
              state_d = S_DONE;
            end
          end
        end
        default: begin
        end
      endcase

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        // once full, the pointer keeps moving and overwrites the oldest slot
        if (count_q != COUNT_MAX) begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Record storage (contents are don't-care after reset, so not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q] <= dbg.wb_pc;
      ir_mem[wr_ptr_q] <= dbg.wb_ir;
      wd_mem[wr_ptr_q] <= dbg.wb_wdata;
    end
  end

  // Oldest valid record sits count slots behind the write pointer. When the
  // buffer is full count[AW-1:0] is 0, which correctly lands on wr_ptr.
  assign rd_slot = wr_ptr_q - count_q[AW-1:0] + dbg.rd_idx;

  always_comb begin
    ir_ext       = '0;
    ir_ext[31:0] = ir_mem[rd_slot];
  end

`ifdef TRACE_GAP_EN
  logic [15:0] gap_q;
  logic        dhs_q;
  logic        chs_q;
  logic [17:0] meta_mem [DEPTH];

  // Gap state tracks idle cycles since the last retirement, so any wb_valid
  // restarts it, even in states that do not write a record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
      dhs_q <= 1'b0;
      chs_q <= 1'b0;
    end else if (dbg.arm || dbg.wb_valid) begin
      gap_q <= '0;
      dhs_q <= 1'b0;
      chs_q <= 1'b0;
    end else begin
      if (gap_q != 16'hFFFF) begin
        gap_q <= gap_q + 16'd1;
      end
      dhs_q <= dhs_q | dbg.data_hazard;
      chs_q <= chs_q | dbg.control_hazard;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      meta_mem[wr_ptr_q] <= {chs_q, dhs_q, gap_q};
    end
  end

  always_comb begin
    meta_ext       = '0;
    meta_ext[17:0] = meta_mem[rd_slot];
  end
`else
  logic unused_hazards;
  assign unused_hazards = dbg.data_hazard ^ dbg.control_hazard;
  assign meta_ext       = '0;
`endif

  // ---------------------------------------------------------------------------
  // Registered readout; indices beyond the valid window read as zero
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if ({1'b0, dbg.rd_idx} >= count_q) begin
      rd_data_q <= '0;
    end else begin
      case (dbg.rd_field)
        2'd0:    rd_data_q <= pc_mem[rd_slot];
        2'd1:    rd_data_q <= ir_ext;
        2'd2:    rd_data_q <= wd_mem[rd_slot];
        default: rd_data_q <= meta_ext;
      endcase
    end
  end

  assign dbg.rd_data = rd_data_q;
  assign dbg.state   = state_q;
  assign dbg.count   = count_q;
  assign dbg.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_rv32_trace_buf.sv
// tb/tb_rv32_trace_buf.sv - Directed self-checking bench for rv32_trace_buf
//
// Two instances: dut_a with POST_CNT = 8 and dut_b with POST_CNT = 0. The
// retire stream and readout selects are shared; arm and trig_pc are per DUT.

module tb_rv32_trace_buf;

`ifdef TRACE_GAP_EN
  localparam logic [31:0] GAP_META = 32'h0001_0003;
`else
  localparam logic [31:0] GAP_META = 32'h0000_0000;
`endif

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_ir;
  logic [31:0] wb_wdata;
  logic        data_hazard;
  logic        control_hazard;
  logic        arm_a;
  logic        arm_b;
  logic        trig_en;
  logic [31:0] trig_pc_a;
  logic [31:0] trig_pc_b;
  logic [3:0]  rd_idx;
  logic [1:0]  rd_field;

  int total;
  int passed;
  int failed;

  rv32_trace_buf_if #(.XLEN(32), .DEPTH(16)) ia ();
  rv32_trace_buf_if #(.XLEN(32), .DEPTH(16)) ib ();

  assign ia.wb_valid       = wb_valid;
  assign ia.wb_pc          = wb_pc;
  assign ia.wb_ir          = wb_ir;
  assign ia.wb_wdata       = wb_wdata;
  assign ia.data_hazard    = data_hazard;
  assign ia.control_hazard = control_hazard;
  assign ia.arm            = arm_a;
  assign ia.trig_en        = trig_en;
  assign ia.trig_pc        = trig_pc_a;
  assign ia.rd_idx         = rd_idx;
  assign ia.rd_field       = rd_field;

  assign ib.wb_valid       = wb_valid;
  assign ib.wb_pc          = wb_pc;
  assign ib.wb_ir          = wb_ir;
  assign ib.wb_wdata       = wb_wdata;
  assign ib.data_hazard    = data_hazard;
  assign ib.control_hazard = control_hazard;
  assign ib.arm            = arm_b;
  assign ib.trig_en        = trig_en;
  assign ib.trig_pc        = trig_pc_b;
  assign ib.rd_idx         = rd_idx;
  assign ib.rd_field       = rd_field;

  rv32_trace_buf #(.XLEN(32), .DEPTH(16), .POST_CNT(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .dbg   (ia)
  );

  rv32_trace_buf #(.XLEN(32), .DEPTH(16), .POST_CNT(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .dbg   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_ir    = 32'hA000_0000 | pc;
    wb_wdata = ~pc;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic rd(input int idx, input int f);
    rd_idx   = idx[3:0];
    rd_field = f[1:0];
    step();
  endtask

  task automatic pulse_arm_a();
    arm_a = 1'b1;
    step();
    arm_a = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    rst_n = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_ir = '0; wb_wdata = '0;
    data_hazard = 1'b0; control_hazard = 1'b0; arm_a = 1'b0; arm_b = 1'b0;
    trig_en = 1'b0; trig_pc_a = '0; trig_pc_b = '0; rd_idx = '0; rd_field = '0;

    // reset state
    #2;
    check("rst_state", 32'(ia.state), 32'd0);
    check("rst_count", 32'(ia.count), 32'd0);
    check("rst_done", 32'(ia.done), 32'd0);
    check("rst_rd_data", ia.rd_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // idle after reset: retirement is not captured
    retire(32'h0000_0100);
    check("idle_no_write", 32'(ia.count), 32'd0);

    // arm with a same-cycle retirement: the record is discarded
    arm_a = 1'b1; wb_valid = 1'b1; wb_pc = 32'h0000_0200;
    step();
    arm_a = 1'b0; wb_valid = 1'b0;
    check("arm_state", 32'(ia.state), 32'd1);
    check("arm_discard_count", 32'(ia.count), 32'd0);

    // five retirements, no trigger
    for (int i = 0; i < 5; i++) retire(32'(4 * i));
    check("five_count", 32'(ia.count), 32'd5);
    check("five_state", 32'(ia.state), 32'd1);
    rd(0, 0); check("five_idx0_pc", ia.rd_data, 32'h0000_0000);
    rd(4, 0); check("five_idx4_pc", ia.rd_data, 32'h0000_0010);
    rd(5, 0); check("five_idx5_zero", ia.rd_data, 32'h0000_0000);
    rd(2, 1); check("five_idx2_ir", ia.rd_data, 32'hA000_0008);
    rd(3, 2); check("five_idx3_wdata", ia.rd_data, 32'hFFFF_FFF3);

    // gap metadata: retire, three idle cycles (hazard in the middle), retire
    pulse_arm_a();
    retire(32'h0000_0100);
    step();
    data_hazard = 1'b1;
    step();
    data_hazard = 1'b0;
    step();
    retire(32'h0000_0104);
    rd(1, 3); check("gap_meta_rec1", ia.rd_data, GAP_META);
    rd(0, 3); check("gap_meta_rec0", ia.rd_data, 32'h0000_0000);
    rd(1, 0); check("gap_rec1_pc", ia.rd_data, 32'h0000_0104);

    // wrap: 20 retirements into 16 slots
    pulse_arm_a();
    for (int i = 0; i < 20; i++) retire(32'(4 * i));
    check("wrap_count", 32'(ia.count), 32'd16);
    rd(0, 0); check("wrap_oldest", ia.rd_data, 32'h0000_0010);
    rd(15, 0); check("wrap_newest", ia.rd_data, 32'h0000_004C);
    rd(0, 2); check("wrap_oldest_wdata", ia.rd_data, 32'hFFFF_FFEF);

    // trigger at 0x20 with eight post-trigger records
    trig_en = 1'b1;
    trig_pc_a = 32'h0000_0020;
    pulse_arm_a();
    for (int i = 0; i <= 8; i++) retire(32'(4 * i));
    check("trig_post_state", 32'(ia.state), 32'd2);
    for (int i = 9; i < 16; i++) retire(32'(4 * i));
    check("trig_post_before_last", 32'(ia.state), 32'd2);
    retire(32'h0000_0040);
    check("trig_done_state", 32'(ia.state), 32'd3);
    check("trig_done_flag", 32'(ia.done), 32'd1);
    check("trig_count", 32'(ia.count), 32'd16);
    rd(15, 0); check("trig_newest", ia.rd_data, 32'h0000_0040);
    rd(0, 0); check("trig_oldest", ia.rd_data, 32'h0000_0004);
    retire(32'h0000_0044);
    retire(32'h0000_0020);
    check("frozen_count", 32'(ia.count), 32'd16);
    check("frozen_state", 32'(ia.state), 32'd3);
    rd(15, 0); check("frozen_newest", ia.rd_data, 32'h0000_0040);
    rd(0, 0); check("frozen_oldest", ia.rd_data, 32'h0000_0004);

    // asynchronous reset in the middle of POST
    pulse_arm_a();
    retire(32'h0000_0020);
    check("mid_post_state", 32'(ia.state), 32'd2);
    retire(32'h0000_0024);
    rd(0, 0); check("mid_rd_data", ia.rd_data, 32'h0000_0020);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(ia.state), 32'd0);
    check("async_rst_count", 32'(ia.count), 32'd0);
    check("async_rst_done", 32'(ia.done), 32'd0);
    check("async_rst_rd_data", ia.rd_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // POST_CNT = 0 instance: trigger at 0x08 goes straight to DONE
    trig_pc_b = 32'h0000_0008;
    arm_b = 1'b1;
    step();
    arm_b = 1'b0;
    retire(32'h0000_0000);
    retire(32'h0000_0004);
    check("b_armed_state", 32'(ib.state), 32'd1);
    retire(32'h0000_0008);
    check("b_done_state", 32'(ib.state), 32'd3);
    check("b_done_flag", 32'(ib.done), 32'd1);
    check("b_count", 32'(ib.count), 32'd3);
    rd(2, 0); check("b_newest_pc", ib.rd_data, 32'h0000_0008);
    rd(2, 1); check("b_newest_ir", ib.rd_data, 32'hA000_0008);
    arm_b = 1'b1;
    step();
    arm_b = 1'b0;
    check("b_rearm_count", 32'(ib.count), 32'd0);
    check("b_rearm_state", 32'(ib.state), 32'd1);
    check("b_rearm_done", 32'(ib.done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
